// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive port: receiver states,
// frame geometry and the odd-parity helpers used on every frame.
package ps2_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // Frame geometry: start + 8 data + parity + stop.
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    // True when data bits plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS:0] bits);
        return ^bits;
    endfunction

    // Parity bit a device appends so that the 9-bit group is odd.
    function automatic logic odd_parity_bit(input logic [DATA_BITS-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_rx_port_if.sv
// Host-side bus of the PS/2 receive port: chip-select read strobe,
// interrupt clear, popped data, FIFO status and error/interrupt flags.
interface ps2_rx_port_if
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic                 cs;
    logic                 int_clear;
    logic [DATA_BITS-1:0] rd_data;
    logic                 data_rdy;
    logic                 fifo_full;
    logic [LVL_W-1:0]     level;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 frame_err;
    logic                 overflow;
    logic                 irq;

    // Host side: drives select and clear, observes everything else.
    modport master (
        output cs, int_clear,
        input  rd_data, data_rdy, fifo_full, level, rx_valid, rx_byte,
        input  frame_err, overflow, irq
    );

    // Port side: the receive block itself.
    modport slave (
        input  cs, int_clear,
        output rd_data, data_rdy, fifo_full, level, rx_valid, rx_byte,
        output frame_err, overflow, irq
    );

endinterface

// File: rtl/ps2_rx_port_sync_fifo.sv
// Single-clock FIFO with registered read data. A push while full is
// accepted only when a pop happens in the same cycle; a pop while
// empty leaves the read data untouched.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [LVL_W-1:0] cnt_r;
    logic [WIDTH-1:0] dout_r;
    logic             rd_en_s;
    logic             wr_en_s;

    assign empty   = (cnt_r == LVL_W'(0));
    assign full    = (cnt_r == LVL_W'(DEPTH));
    assign rd_en_s = pop & ~empty;
    assign wr_en_s = push & (~full | rd_en_s);
    assign level   = cnt_r;
    assign dout    = dout_r;

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cnt_r  <= '0;
            dout_r <= '0;
        end else begin
            if (wr_en_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (rd_en_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
                dout_r <= mem_r[rptr_r];
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   cnt_r <= cnt_r + LVL_W'(1);
                2'b01:   cnt_r <= cnt_r - LVL_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_port.sv
// PS/2 device-to-host receive port: synchronises and glitch-filters the
// pad lines, deframes 11-bit frames with parity/stop/timeout checking,
// buffers good bytes and raises interrupts toward the host bus.
module ps2_rx_port
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int FILTER_LEN     = 4,
    parameter int CS_STABLE      = 2,
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int IRQ_THRESHOLD  = 1
) (
    input logic           clk,
    input logic           rst_n,
    input logic           ps2_clk,
    input logic           ps2_data,
    ps2_rx_port_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int FL_W  = $clog2(FILTER_LEN + 1);
    localparam int CS_W  = $clog2(CS_STABLE + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BC_W  = $clog2(DATA_BITS);

    // Synchroniser chains; PS/2 lines idle high, chip select idles low.
    logic [1:0] clk_sync_r;
    logic [1:0] data_sync_r;
    logic [1:0] cs_sync_r;

    // Glitch filters.
    logic            clk_filt_r;
    logic            data_filt_r;
    logic [FL_W-1:0] clk_fcnt_r;
    logic [FL_W-1:0] data_fcnt_r;
    logic            clk_flip_s;
    logic            data_flip_s;
    logic            fall_s;

    // Receiver.
    rx_state_e            state_r, state_n;
    logic [BC_W-1:0]      bit_cnt_r, bit_cnt_n;
    logic [DATA_BITS-1:0] shift_r, shift_n;
    logic                 par_r, par_n;
    logic [TO_W-1:0]      to_cnt_r, to_cnt_n;
    logic                 accept_s;
    logic                 ferr_s;
    logic                 rx_valid_r;
    logic [DATA_BITS-1:0] rx_byte_r;

    // Read strobe, FIFO and flags.
    logic [CS_W-1:0]      cs_cnt_r;
    logic                 cs_fired_r;
    logic                 rd_strobe_r;
    logic [DATA_BITS-1:0] fifo_dout_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [LVL_W-1:0]     fifo_level_s;
    logic                 ovf_s;
    logic                 frame_err_r;
    logic                 overflow_r;
    logic                 irq_r;

    // Two-flop synchronisers for the three asynchronous inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
            cs_sync_r   <= 2'b00;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
            cs_sync_r   <= {cs_sync_r[0], bus.cs};
        end
    end

    // A filtered line flips on the cycle its disagreement count completes;
    // a flip of the filtered clock from 1 is the receiver's bit edge.
    assign clk_flip_s  = (clk_sync_r[1] != clk_filt_r) &&
                         (clk_fcnt_r == FL_W'(FILTER_LEN - 1));
    assign data_flip_s = (data_sync_r[1] != data_filt_r) &&
                         (data_fcnt_r == FL_W'(FILTER_LEN - 1));
    assign fall_s      = clk_flip_s & clk_filt_r;

    // PS/2 clock filter: follow the input only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt_r <= 1'b1;
            clk_fcnt_r <= '0;
        end else if (clk_sync_r[1] == clk_filt_r) begin
            clk_fcnt_r <= '0;
        end else if (clk_flip_s) begin
            clk_filt_r <= clk_sync_r[1];
            clk_fcnt_r <= '0;
        end else begin
            clk_fcnt_r <= clk_fcnt_r + FL_W'(1);
        end
    end

    // PS/2 data filter, same rule as the clock filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_filt_r <= 1'b1;
            data_fcnt_r <= '0;
        end else if (data_sync_r[1] == data_filt_r) begin
            data_fcnt_r <= '0;
        end else if (data_flip_s) begin
            data_filt_r <= data_sync_r[1];
            data_fcnt_r <= '0;
        end else begin
            data_fcnt_r <= data_fcnt_r + FL_W'(1);
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            par_r     <= 1'b0;
            to_cnt_r  <= '0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            par_r     <= par_n;
            to_cnt_r  <= to_cnt_n;
        end
    end

    // Receiver next state: advance on each filtered clock fall, abandon the
    // frame if the gap between falls inside a frame grows too long.
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        shift_n   = shift_r;
        par_n     = par_r;
        to_cnt_n  = to_cnt_r;
        accept_s  = 1'b0;
        ferr_s    = 1'b0;
        if (fall_s) begin
            to_cnt_n = '0;
            case (state_r)
                IDLE: begin
                    if (!data_filt_r) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                DATA: begin
                    shift_n = {data_filt_r, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == BC_W'(DATA_BITS - 1)) begin
                        state_n = PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt_r + BC_W'(1);
                    end
                end
                PARITY: begin
                    par_n   = data_filt_r;
                    state_n = STOP;
                end
                STOP: begin
                    if (data_filt_r && odd_parity_ok({par_r, shift_r})) begin
                        accept_s = 1'b1;
                    end else begin
                        ferr_s = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end else if (state_r != IDLE) begin
            if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_n  = IDLE;
                ferr_s   = 1'b1;
                to_cnt_n = '0;
            end else begin
                to_cnt_n = to_cnt_r + TO_W'(1);
            end
        end else begin
            to_cnt_n = '0;
        end
    end

    // Accepted byte is presented for one cycle and pushed in that same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_r <= 1'b0;
            rx_byte_r  <= '0;
        end else begin
            rx_valid_r <= accept_s;
            rx_byte_r  <= accept_s ? shift_r : rx_byte_r;
        end
    end

    // Read strobe: one pulse per chip-select assertion once it has stayed high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_cnt_r    <= '0;
            cs_fired_r  <= 1'b0;
            rd_strobe_r <= 1'b0;
        end else begin
            rd_strobe_r <= 1'b0;
            if (!cs_sync_r[1]) begin
                cs_cnt_r   <= '0;
                cs_fired_r <= 1'b0;
            end else if (!cs_fired_r) begin
                if (cs_cnt_r == CS_W'(CS_STABLE - 1)) begin
                    rd_strobe_r <= 1'b1;
                    cs_fired_r  <= 1'b1;
                    cs_cnt_r    <= '0;
                end else begin
                    cs_cnt_r <= cs_cnt_r + CS_W'(1);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_valid_r),
        .pop   (rd_strobe_r),
        .din   (rx_byte_r),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // A byte is lost only when full and nothing leaves in the same cycle.
    assign ovf_s = rx_valid_r & fifo_full_s & ~rd_strobe_r;

    // Sticky flags and interrupt; a new set event beats a concurrent clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
            overflow_r  <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            frame_err_r <= ferr_s ? 1'b1 : (bus.int_clear ? 1'b0 : frame_err_r);
            overflow_r  <= ovf_s  ? 1'b1 : (bus.int_clear ? 1'b0 : overflow_r);
            if (ferr_s || ovf_s) begin
                irq_r <= 1'b1;
            end else if (bus.int_clear) begin
                irq_r <= 1'b0;
            end else if (fifo_level_s >= LVL_W'(IRQ_THRESHOLD)) begin
                irq_r <= 1'b1;
            end else begin
                irq_r <= irq_r;
            end
        end
    end

    assign bus.rd_data   = fifo_dout_s;
    assign bus.data_rdy  = ~fifo_empty_s;
    assign bus.fifo_full = fifo_full_s;
    assign bus.level     = fifo_level_s;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.rx_byte   = rx_byte_r;
    assign bus.frame_err = frame_err_r;
    assign bus.overflow  = overflow_r;
    assign bus.irq       = irq_r;

endmodule

// File: tb/tb_ps2_rx_port.sv
// Directed + randomized bench for ps2_rx_port with a queue-based model.
`timescale 1ns/1ps
module tb_ps2_rx_port;
    localparam int DEPTH          = 8;
    localparam int FILTER_LEN     = 4;
    localparam int CS_STABLE      = 2;
    localparam int TIMEOUT_CYCLES = 600;
    localparam int IRQ_THRESHOLD  = 1;
    localparam int HALF           = 40;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_rx_port_if #(.DEPTH(DEPTH)) bus ();

    ps2_rx_port #(
        .DEPTH          (DEPTH),
        .FILTER_LEN     (FILTER_LEN),
        .CS_STABLE      (CS_STABLE),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .IRQ_THRESHOLD  (IRQ_THRESHOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int fail_cnt = 0;
    int rx_cnt   = 0;

    logic [7:0] q[$];
    logic       exp_ferr = 1'b0;
    logic       exp_ovf  = 1'b0;
    logic       exp_irq  = 1'b0;
    int         exp_rx_cnt = 0;
    logic [7:0] exp_rd  = 8'h00;
    logic [7:0] last_rx = 8'h00;

    // Count accepted-frame pulses.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) rx_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Device-side frame: data changes while clock high, host samples on fall.
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input int stall_after, input int cs_delay);
        logic [10:0] bits;
        bits = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (stall_after >= 0 && i == stall_after + 1) begin
                ps2_data = 1'b1;
                cyc(TIMEOUT_CYCLES + 100);
                return;
            end
            ps2_data = bits[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            if (i == 10 && cs_delay >= 0) begin
                cyc(cs_delay);
                bus.cs = 1'b1;
                cyc(HALF - cs_delay);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        bus.cs   = 1'b0;
        cyc(2 * HALF);
    endtask

    // Reference behaviour of one complete frame arriving.
    task automatic model_frame(input logic [7:0] b, input bit good);
        if (good) begin
            exp_rx_cnt++;
            last_rx = b;
            if (q.size() < DEPTH) q.push_back(b);
            else begin
                exp_ovf = 1'b1;
                exp_irq = 1'b1;
            end
            if (q.size() >= IRQ_THRESHOLD) exp_irq = 1'b1;
        end else begin
            exp_ferr = 1'b1;
            exp_irq  = 1'b1;
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ferr"}, bus.frame_err, exp_ferr);
        check({tag, "_ovf"},  bus.overflow,  exp_ovf);
        check({tag, "_irq"},  bus.irq,       exp_irq);
        check({tag, "_lvl"},  bus.level,     q.size());
        check({tag, "_rdy"},  bus.data_rdy,  q.size() != 0);
        check({tag, "_full"}, bus.fifo_full, q.size() == DEPTH);
        check({tag, "_rxn"},  rx_cnt,        exp_rx_cnt);
    endtask

    task automatic do_read(input int hold, input string tag);
        bus.cs = 1'b1;
        cyc(hold);
        bus.cs = 1'b0;
        cyc(6);
        if (q.size() > 0) exp_rd = q.pop_front();
        check({tag, "_rd"},  bus.rd_data, exp_rd);
        check({tag, "_lvl"}, bus.level,   q.size());
    endtask

    task automatic clear_int();
        bus.int_clear = 1'b1;
        cyc(1);
        bus.int_clear = 1'b0;
        cyc(3);
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        exp_irq  = (q.size() >= IRQ_THRESHOLD);
    endtask

    initial begin
        logic [7:0] rb;
        bit         bad;
        bus.cs        = 1'b0;
        bus.int_clear = 1'b0;
        cyc(5);
        rst_n = 1'b1;
        cyc(3);

        // Reset state.
        check("rst_rd",   bus.rd_data,   8'h00);
        check("rst_rxb",  bus.rx_byte,   8'h00);
        check("rst_rxv",  bus.rx_valid,  1'b0);
        check_flags("rst");

        // Good frame 0x1C, then one CS read.
        send_frame(8'h1C, 1'b0, -1, -1);
        model_frame(8'h1C, 1'b1);
        check_flags("f1c");
        check("f1c_rxb", bus.rx_byte, 8'h1C);
        do_read(5, "rd1c");
        clear_int();
        check_flags("clr1");

        // Bad parity on 0xF0.
        send_frame(8'hF0, 1'b1, -1, -1);
        model_frame(8'hF0, 1'b0);
        check_flags("par");
        clear_int();
        check_flags("clr2");

        // Stall after four data bits, then a good 0x5A.
        send_frame(8'hA5, 1'b0, 4, -1);
        exp_ferr = 1'b1;
        exp_irq  = 1'b1;
        check_flags("tmo");
        clear_int();
        send_frame(8'h5A, 1'b0, -1, -1);
        model_frame(8'h5A, 1'b1);
        check_flags("f5a");
        check("f5a_rxb", bus.rx_byte, 8'h5A);
        do_read(4, "rd5a");
        clear_int();

        // Nine frames into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) begin
            rb = 8'(i);
            send_frame(rb, 1'b0, -1, -1);
            model_frame(rb, 1'b1);
        end
        check_flags("ovf");
        clear_int();
        check_flags("clr3");
        for (int i = 0; i < 8; i++) do_read(3, "rdovf");
        clear_int();

        // Glitches on ps2_clk (while data low) and on cs.
        ps2_data = 1'b0;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(1);
        ps2_clk = 1'b1;
        cyc(10);
        ps2_data = 1'b1;
        cyc(20);
        rb = 8'($urandom_range(0, 255));
        send_frame(rb, 1'b0, -1, -1);
        model_frame(rb, 1'b1);
        check_flags("glk");
        check("glk_rxb", bus.rx_byte, rb);
        bus.cs = 1'b1;
        cyc(1);
        bus.cs = 1'b0;
        cyc(8);
        check("gcs_lvl", bus.level, q.size());
        check("gcs_rd",  bus.rd_data, exp_rd);
        rb = 8'($urandom_range(0, 255));
        send_frame(rb, 1'b0, -1, -1);
        model_frame(rb, 1'b1);
        bus.cs = 1'b1;
        cyc(100);
        bus.cs = 1'b0;
        cyc(6);
        exp_rd = q.pop_front();
        check("hold_rd",  bus.rd_data, exp_rd);
        check("hold_lvl", bus.level,   q.size());
        while (q.size() > 0) do_read(3, "rdg");
        clear_int();

        // Random frames, some with corrupted parity.
        for (int i = 0; i < 6; i++) begin
            rb  = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            send_frame(rb, bad, -1, -1);
            model_frame(rb, !bad);
            check_flags("rnd");
            if (!bad) check("rnd_rxb", bus.rx_byte, last_rx);
        end
        while (q.size() > 0) do_read($urandom_range(3, 8), "rdrnd");
        clear_int();

        // Fill, then push and pop in the same cycle.
        for (int i = 0; i < DEPTH; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, 1'b0, -1, -1);
            model_frame(rb, 1'b1);
        end
        check_flags("fill");
        rb = 8'($urandom_range(0, 255));
        send_frame(rb, 1'b0, -1, 2);
        exp_rx_cnt++;
        exp_rd = q.pop_front();
        q.push_back(rb);
        check("both_rd",   bus.rd_data,   exp_rd);
        check("both_lvl",  bus.level,     DEPTH);
        check("both_ovf",  bus.overflow,  1'b0);
        check("both_full", bus.fifo_full, 1'b1);
        check("both_rxn",  rx_cnt,        exp_rx_cnt);
        while (q.size() > 0) do_read(3, "rdboth");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
